tcp_vlg_tx_stream_mon: RTL and testbench
========================================

Name: tcp_vlg_tx_stream_mon

Overview:
Synthesizable, parametrised run-time monitor for the user-logic → TCP transmit stream handshake. It generalises the single cts/val assertion to N_CH channels and adds these checks:
- configurable cts-fall grace latency;
- packet framing (sof/eof);
- maximum packet length.

Each channel reports sticky error flags, a one-cycle error pulse and a saturating violation counter. It sits beside each TCP tx_ctl instance and feeds status registers and debug logic; it is not in the data path.

Parameters:
N_CH, 1, number of independent tx streams monitored
CTS_LAT, 0, cycles val may remain high after cts falls (0 = val must be low the cycle after the fall)
MAX_LEN, 1460, maximum legal packet length in valid beats
LEN_W, 16, width of the per-channel length counter
CNT_W, 16, width of the per-channel violation counter

Ports:
clk       in   1            system clock
rst       in   1            synchronous active-high reset
val       in   N_CH         per-channel user data valid
sof       in   N_CH         per-channel start of frame, qualified by val
eof       in   N_CH         per-channel end of frame, qualified by val
cts       in   N_CH         per-channel clear-to-send from TCP
clr       in   1            synchronous clear of sticky flags and counters, all channels
err_cts   out  N_CH         sticky: val high outside the cts grace window
err_sof   out  N_CH         sticky: val without sof while idle, or sof inside a packet
err_len   out  N_CH         sticky: packet exceeded MAX_LEN beats
err_pulse out  N_CH         one-cycle pulse on any new violation
err_cnt   out  N_CH*CNT_W   per-channel violation count, channel i at [i*CNT_W +: CNT_W]

Behaviour:
- One clock domain; reset is synchronous and active-high. All outputs are registered, so flags and counters change 1 cycle after the violating input cycle.
- Reset values:
  - err_* = 0, err_pulse = 0, err_cnt = 0;
  - state = IDLE, len = 0, cts_q = 0;
  - since_fall saturated, so val with cts low straight after reset is a violation.
- CTS window (per channel):
  - fall = !cts & cts_q.
  - sf = fall ? 0 : sat(sf_q+1) while cts low; sf_q holds (no change) while cts high.
  - Violation when val & !cts & (sf > CTS_LAT).
  - With CTS_LAT=0: val is allowed on the fall cycle and forbidden from the next cycle onward.
  - cts rising ends the window; no violation while cts is high.
  - sf saturates at CTS_LAT+1; it never wraps.
- Framing FSM, states IDLE and PKT (beat = val high):
  - IDLE, val&sof&eof → IDLE (single-beat packet, len checked as 1).
  - IDLE, val&sof&!eof → PKT, len=1.
  - IDLE, val&!sof → sof violation, stay IDLE.
  - PKT, val&sof → sof violation; treat as a new packet start, len=1; go to IDLE if eof is also high.
  - PKT, val&eof → IDLE, len cleared.
  - PKT, val → len=sat(len+1).
  - sof/eof with val low are ignored.
- Length check: a len violation fires once per packet, on the beat where len becomes MAX_LEN+1. The len counter saturates at 2^LEN_W-1.
- Multiple violation types in one cycle:
  - set every corresponding flag;
  - pulse err_pulse once;
  - increment err_cnt by 1 (the count is of violating cycles).
- err_cnt saturates at 2^CNT_W-1.
- clr clears flags and counters only; it does not reset FSM, len or sf. If clr and a violation occur in the same cycle, the violation wins: flag=1, cnt=1.
- rst mid-packet aborts the packet. The next beat must carry sof.

Decomposition:
- Shared package (eth_vlg_pkg): mon_state_t enum {IDLE, PKT}; error-bit index constants ERR_CTS, ERR_SOF, ERR_LEN; typedef mon_err_t as a packed struct of the three bits.
- Sub-module tcp_vlg_tx_stream_mon_ch holds all per-channel logic: cts window, FSM, len, flags, counter. The top level is a generate loop over N_CH plus port slicing.

Test Plan:
- CTS_LAT=0: cts 1→0 at t0, val high at t0 and t0+1 → err_cts=1 and err_pulse at t0+2, err_cnt=1.
- CTS_LAT=2: cts falls at t0, val high t0..t0+2 then low → no error. val high again at t0+3 with cts still low → err_cts, err_cnt=1.
- Framing: beat with val=1, sof=0 in IDLE → err_sof. Then sof, 3 beats, sof again mid-packet → err_cnt=2; the following eof returns to IDLE cleanly.
- MAX_LEN=4: packet of 6 beats → err_len on beat 5 only, err_cnt=1. Next 4-beat packet → no change.
- Saturation/clear with CNT_W=2: 5 violating cycles → err_cnt=3. clr together with a violation → err_cnt=1, flag set. Plain clr → all 0.
- N_CH=2 isolation: violations on channel 1 only → channel 0 flags and count stay 0. rst mid-packet, then a beat without sof → err_sof.

Source files
------------

// File: rtl/eth_vlg_pkg.sv
// Shared types for the TCP tx stream monitor: framing states and error bits.
package eth_vlg_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PKT  = 1'b1
  } mon_state_t;

  localparam int ERR_CTS = 0;
  localparam int ERR_SOF = 1;
  localparam int ERR_LEN = 2;
  localparam int ERR_W   = 3;

  // Field order matches the ERR_* bit indices (first field is the MSB).
  typedef struct packed {
    logic len;
    logic sof;
    logic cts;
  } mon_err_t;

endpackage

// File: rtl/tcp_vlg_tx_stream_mon_ch.sv
// Per-channel monitor: cts grace window, sof/eof framing FSM, packet
// length check, sticky flags, error pulse and saturating violation count.
module tcp_vlg_tx_stream_mon_ch
  import eth_vlg_pkg::*;
#(
  parameter int CTS_LAT = 0,
  parameter int MAX_LEN = 1460,
  parameter int LEN_W   = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_val,
  input  logic             i_sof,
  input  logic             i_eof,
  input  logic             i_cts,
  input  logic             i_clr,
  output logic             o_err_cts,
  output logic             o_err_sof,
  output logic             o_err_len,
  output logic             o_err_pulse,
  output logic [CNT_W-1:0] o_err_cnt
);

  // Cycles-since-fall only needs to count one past the grace latency.
  localparam int               SF_W    = $clog2(CTS_LAT + 2);
  localparam logic [SF_W-1:0]  SF_SAT  = SF_W'(CTS_LAT + 1);
  localparam logic [LEN_W-1:0] LEN_SAT = '1;
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  logic             r_cts_q;
  logic [SF_W-1:0]  r_sf;
  mon_state_t       r_state;
  logic [LEN_W-1:0] r_len;
  mon_err_t         r_err;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;

  logic             w_fall;
  logic [SF_W-1:0]  w_sf;
  logic             w_cts_viol;
  mon_state_t       w_state;
  logic [LEN_W-1:0] w_len;
  logic [LEN_W-1:0] w_len_inc;
  logic [LEN_W-1:0] w_beat_len;
  logic             w_sof_viol;
  logic             w_len_viol;
  mon_err_t         w_viol;
  logic             w_any;
  logic [ERR_W-1:0] w_err_bits;

  // Grace window: restart on the cts fall, count while cts stays low, hold while high.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no latch is inferred.
    w_fall = ~i_cts & r_cts_q;
    w_sf   = r_sf;
    if (!i_cts) begin
      if (w_fall)
        w_sf = '0;
      else if (r_sf != SF_SAT)
        w_sf = r_sf + SF_W'(1);
    end
    w_cts_viol = i_val & ~i_cts & (int'(w_sf) > CTS_LAT);
  end

  // Framing next-state: a sof beat always (re)starts a packet, even when it is illegal.
  always_comb begin
    w_state    = r_state;
    w_len      = r_len;
    w_beat_len = '0;
    w_sof_viol = 1'b0;
    w_len_inc  = (r_len == LEN_SAT) ? r_len : r_len + LEN_W'(1);
    if (i_val) begin
      case (r_state)
        IDLE: begin
          if (i_sof) begin
            w_beat_len = LEN_W'(1);
            w_len      = i_eof ? '0 : LEN_W'(1);
            w_state    = i_eof ? IDLE : PKT;
          end else begin
            w_sof_viol = 1'b1;
          end
        end
        PKT: begin
          if (i_sof) begin
            w_sof_viol = 1'b1;
            w_beat_len = LEN_W'(1);
            w_len      = i_eof ? '0 : LEN_W'(1);
          end else begin
            w_beat_len = w_len_inc;
            w_len      = i_eof ? '0 : w_len_inc;
          end
          w_state = i_eof ? IDLE : PKT;
        end
        default: w_state = IDLE;
      endcase
    end
    // Non-beats leave w_beat_len at 0, which never equals MAX_LEN+1.
    w_len_viol = (int'(w_beat_len) == MAX_LEN + 1);
  end

  assign w_viol = '{len: w_len_viol, sof: w_sof_viol, cts: w_cts_viol};
  assign w_any  = |w_viol;

  // Window and framing state; reset aborts any packet in flight.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      r_cts_q <= 1'b0;
      r_sf    <= SF_SAT;
      r_state <= IDLE;
      r_len   <= '0;
    end else begin
      r_cts_q <= i_cts;
      r_sf    <= w_sf;
      r_state <= w_state;
      r_len   <= w_len;
    end
  end

  // Error reporting; a violation in the same cycle as clr survives the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err   <= '0;
      r_pulse <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_pulse <= w_any;
      if (i_clr) begin
        r_err <= w_viol;
        r_cnt <= w_any ? CNT_W'(1) : '0;
      end else begin
        r_err <= mon_err_t'(r_err | w_viol);
        if (w_any && (r_cnt != CNT_SAT))
          r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign w_err_bits  = r_err;
  assign o_err_cts   = w_err_bits[ERR_CTS];
  assign o_err_sof   = w_err_bits[ERR_SOF];
  assign o_err_len   = w_err_bits[ERR_LEN];
  assign o_err_pulse = r_pulse;
  assign o_err_cnt   = r_cnt;

endmodule

// File: rtl/tcp_vlg_tx_stream_mon.sv
// N_CH-channel run-time monitor for the user-logic to TCP tx handshake.
// Each channel is independent; the top only replicates and slices.
module tcp_vlg_tx_stream_mon
  import eth_vlg_pkg::*;
#(
  parameter int N_CH    = 1,
  parameter int CTS_LAT = 0,
  parameter int MAX_LEN = 1460,
  parameter int LEN_W   = 16,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       i_val,
  input  logic [N_CH-1:0]       i_sof,
  input  logic [N_CH-1:0]       i_eof,
  input  logic [N_CH-1:0]       i_cts,
  input  logic                  i_clr,
  output logic [N_CH-1:0]       o_err_cts,
  output logic [N_CH-1:0]       o_err_sof,
  output logic [N_CH-1:0]       o_err_len,
  output logic [N_CH-1:0]       o_err_pulse,
  output logic [N_CH*CNT_W-1:0] o_err_cnt
);

  // One monitor per channel; channel i owns count slice [i*CNT_W +: CNT_W].
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    tcp_vlg_tx_stream_mon_ch #(
      .CTS_LAT (CTS_LAT),
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W),
      .CNT_W   (CNT_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .i_val       (i_val[i]),
      .i_sof       (i_sof[i]),
      .i_eof       (i_eof[i]),
      .i_cts       (i_cts[i]),
      .i_clr       (i_clr),
      .o_err_cts   (o_err_cts[i]),
      .o_err_sof   (o_err_sof[i]),
      .o_err_len   (o_err_len[i]),
      .o_err_pulse (o_err_pulse[i]),
      .o_err_cnt   (o_err_cnt[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_tcp_vlg_tx_stream_mon.sv
// Scoreboard bench. Two monitors: A (2 channels, CTS_LAT=0, MAX_LEN=4,
// CNT_W=2) and B (1 channel, CTS_LAT=2). Each stimulus cycle pushes the
// hand-computed registered response; a negedge monitor pops and compares.
module tb_tcp_vlg_tx_stream_mon;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor A stimulus / response
  logic       rst_a, clr_a;
  logic [1:0] val_a, sof_a, eof_a, cts_a;
  logic [1:0] ects_a, esof_a, elen_a, epul_a;
  logic [3:0] cnt_a;

  // Monitor B stimulus / response
  logic       rst_b, clr_b;
  logic [0:0] val_b, sof_b, eof_b, cts_b;
  logic [0:0] ects_b, esof_b, elen_b, epul_b;
  logic [15:0] cnt_b;

  tcp_vlg_tx_stream_mon #(
    .N_CH(2), .CTS_LAT(0), .MAX_LEN(4), .LEN_W(16), .CNT_W(2)
  ) dut_a (
    .clk(clk), .rst(rst_a), .i_val(val_a), .i_sof(sof_a), .i_eof(eof_a),
    .i_cts(cts_a), .i_clr(clr_a), .o_err_cts(ects_a), .o_err_sof(esof_a),
    .o_err_len(elen_a), .o_err_pulse(epul_a), .o_err_cnt(cnt_a)
  );

  tcp_vlg_tx_stream_mon #(
    .N_CH(1), .CTS_LAT(2), .MAX_LEN(1460), .LEN_W(16), .CNT_W(16)
  ) dut_b (
    .clk(clk), .rst(rst_b), .i_val(val_b), .i_sof(sof_b), .i_eof(eof_b),
    .i_cts(cts_b), .i_clr(clr_b), .o_err_cts(ects_b), .o_err_sof(esof_b),
    .o_err_len(elen_b), .o_err_pulse(epul_b), .o_err_cnt(cnt_b)
  );

  // sel: 0 = A channel 0, 1 = A channel 1, 2 = B. fl = {len, sof, cts}.
  typedef struct {
    int         sel;
    logic [2:0] fl;
    logic       pu;
    int         cnt;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  localparam logic [2:0] F0   = 3'b000;
  localparam logic [2:0] FCTS = 3'b001;
  localparam logic [2:0] FSOF = 3'b010;
  localparam logic [2:0] FLEN = 3'b100;
  localparam logic [2:0] FCS  = 3'b011;

  task automatic check(input string nm, input logic [2:0] got_fl, input logic got_pu,
                       input logic [15:0] got_cnt, input logic [2:0] exp_fl,
                       input logic exp_pu, input int exp_cnt);
    n_checks++;
    if (got_fl === exp_fl && got_pu === exp_pu && got_cnt === 16'(exp_cnt))
      n_pass++;
    else
      $display("FAIL %s: got flags=%b pulse=%b cnt=%0d, expected flags=%b pulse=%b cnt=%0d",
               nm, got_fl, got_pu, got_cnt, exp_fl, exp_pu, exp_cnt);
  endtask

  // Monitor: one registered response per cycle, compared against the scoreboard.
  always @(negedge clk) begin
    if (q.size() != 0) begin : mon
      exp_t        e;
      logic [2:0]  f;
      logic        p;
      logic [15:0] c;
      e = q.pop_front();
      case (e.sel)
        0: begin f = {elen_a[0], esof_a[0], ects_a[0]}; p = epul_a[0]; c = 16'(cnt_a[1:0]); end
        1: begin f = {elen_a[1], esof_a[1], ects_a[1]}; p = epul_a[1]; c = 16'(cnt_a[3:2]); end
        default: begin f = {elen_b[0], esof_b[0], ects_b[0]}; p = epul_b[0]; c = cnt_b; end
      endcase
      check(e.nm, f, p, c, e.fl, e.pu, e.cnt);
    end
  end

  // Queue the response expected after the next edge, then let that edge happen.
  task automatic cyc(input int sel, input logic [2:0] fl, input logic pu,
                     input int cnt, input string nm);
    exp_t e;
    e.sel = sel; e.fl = fl; e.pu = pu; e.cnt = cnt; e.nm = nm;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int ch, input logic v, input logic s, input logic e, input logic c);
    val_a[ch] = v; sof_a[ch] = s; eof_a[ch] = e; cts_a[ch] = c;
  endtask

  task automatic set_b(input logic v, input logic s, input logic e, input logic c);
    val_b[0] = v; sof_b[0] = s; eof_b[0] = e; cts_b[0] = c;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    rst_a = 1'b1; clr_a = 1'b0; val_a = '0; sof_a = '0; eof_a = '0; cts_a = 2'b11;
    rst_b = 1'b1; clr_b = 1'b0; val_b = '0; sof_b = '0; eof_b = '0; cts_b = 1'b1;

    // ---- Monitor A: reset values
    cyc(0, F0, 1'b0, 0, "a_rst_ch0");
    cyc(1, F0, 1'b0, 0, "a_rst_ch1");
    rst_a = 1'b0;

    // ---- CTS_LAT=0: val allowed on the fall cycle, not the next
    set_a(0, 0, 0, 0, 1); cyc(0, F0,   1'b0, 0, "cts_pre");
    set_a(0, 1, 1, 1, 0); cyc(0, F0,   1'b0, 0, "cts_fall_beat");
    set_a(0, 1, 1, 1, 0); cyc(0, FCTS, 1'b1, 1, "cts_lat0_viol");
    set_a(0, 0, 0, 0, 0); cyc(0, FCTS, 1'b0, 1, "cts_sticky");
    set_a(0, 0, 0, 0, 1); clr_a = 1'b1; cyc(0, F0, 1'b0, 0, "clr_cts"); clr_a = 1'b0;

    // ---- Framing
    set_a(0, 1, 0, 0, 1); cyc(0, FSOF, 1'b1, 1, "sof_missing");
    set_a(0, 1, 1, 0, 1); cyc(0, FSOF, 1'b0, 1, "pkt_start");
    set_a(0, 1, 0, 0, 1); cyc(0, FSOF, 1'b0, 1, "pkt_beat2");
                          cyc(0, FSOF, 1'b0, 1, "pkt_beat3");
    set_a(0, 1, 1, 0, 1); cyc(0, FSOF, 1'b1, 2, "sof_mid");
    set_a(0, 1, 0, 1, 1); cyc(0, FSOF, 1'b0, 2, "eof_clean");
    set_a(0, 1, 1, 1, 1); cyc(0, FSOF, 1'b0, 2, "single_beat_idle");
    set_a(0, 0, 0, 0, 1); clr_a = 1'b1; cyc(0, F0, 1'b0, 0, "clr_frm"); clr_a = 1'b0;

    // ---- MAX_LEN=4: 6-beat packet flags beat 5 only, then a legal 4-beat packet
    set_a(0, 1, 1, 0, 1); cyc(0, F0, 1'b0, 0, "len_b1");
    set_a(0, 1, 0, 0, 1);
    for (int i = 2; i <= 4; i++) cyc(0, F0, 1'b0, 0, "len_b2_4");
    cyc(0, FLEN, 1'b1, 1, "len_b5");
    set_a(0, 1, 0, 1, 1); cyc(0, FLEN, 1'b0, 1, "len_b6_eof");
    set_a(0, 1, 1, 0, 1); cyc(0, FLEN, 1'b0, 1, "len4_b1");
    set_a(0, 1, 0, 0, 1); cyc(0, FLEN, 1'b0, 1, "len4_b2");
                          cyc(0, FLEN, 1'b0, 1, "len4_b3");
    set_a(0, 1, 0, 1, 1); cyc(0, FLEN, 1'b0, 1, "len4_eof");
    set_a(0, 0, 0, 0, 1); clr_a = 1'b1; cyc(0, F0, 1'b0, 0, "clr_len"); clr_a = 1'b0;

    // ---- CNT_W=2 saturation and clear priority
    set_a(0, 1, 0, 0, 1);
    for (int i = 1; i <= 5; i++) cyc(0, FSOF, 1'b1, (i > 3) ? 3 : i, "cnt_sat");
    clr_a = 1'b1; cyc(0, FSOF, 1'b1, 1, "clr_with_viol");
    set_a(0, 0, 0, 0, 1); cyc(0, F0, 1'b0, 0, "clr_plain");
    clr_a = 1'b0;

    // ---- Two violation types in one cycle count once
    set_a(0, 0, 0, 0, 0); cyc(0, F0,  1'b0, 0, "multi_fall");
    set_a(0, 1, 0, 0, 0); cyc(0, FCS, 1'b1, 1, "multi_type");
    set_a(0, 0, 0, 0, 1); cyc(0, FCS, 1'b0, 1, "multi_hold");
    clr_a = 1'b1; cyc(0, F0, 1'b0, 0, "clr_multi"); clr_a = 1'b0;

    // ---- Channel isolation and reset mid-packet on channel 1
    set_a(1, 1, 0, 0, 1); cyc(1, FSOF, 1'b1, 1, "iso_ch1_viol");
                          cyc(0, F0,   1'b0, 0, "iso_ch0_clean");
    set_a(1, 1, 1, 0, 1); cyc(1, FSOF, 1'b0, 2, "ch1_pkt_start");
    set_a(1, 0, 0, 0, 1); rst_a = 1'b1; cyc(1, F0, 1'b0, 0, "rst_mid_pkt"); rst_a = 1'b0;
    set_a(1, 1, 0, 0, 1); cyc(1, FSOF, 1'b1, 1, "rst_abort_sof");
    set_a(1, 0, 0, 0, 1); cyc(0, F0,   1'b0, 0, "iso_ch0_final");

    // ---- Monitor B: CTS_LAT=2
    cyc(2, F0, 1'b0, 0, "b_rst");
    rst_b = 1'b0;
    set_b(0, 0, 0, 1); cyc(2, F0,   1'b0, 0, "b_pre");
    set_b(1, 1, 1, 0); cyc(2, F0,   1'b0, 0, "b_t0");
                       cyc(2, F0,   1'b0, 0, "b_t1");
                       cyc(2, F0,   1'b0, 0, "b_t2_edge");
                       cyc(2, FCTS, 1'b1, 1, "b_t3_late");
    set_b(0, 0, 0, 0); cyc(2, FCTS, 1'b0, 1, "b_hold");
    set_b(1, 1, 1, 1); cyc(2, FCTS, 1'b0, 1, "b_cts_high");
    set_b(0, 0, 0, 0); rst_b = 1'b1; cyc(2, F0, 1'b0, 0, "b_rst2"); rst_b = 1'b0;
    set_b(1, 1, 1, 0); cyc(2, FCTS, 1'b1, 1, "b_post_rst");
    set_b(0, 0, 0, 1);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d responses still pending, expected 0", q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
